// File: rtl/mx_block_serializer.sv
// Width converter for MXINT streams: takes one IN_SIZE-mantissa block per handshake
// and replays it as IN_SIZE/OUT_SIZE beats of OUT_SIZE mantissas with the shared exponent.
module mx_block_serializer #(
  parameter int unsigned MAN_WIDTH = 8,
  parameter int unsigned EXP_WIDTH = 8,
  parameter int unsigned IN_SIZE   = 8,
  parameter int unsigned OUT_SIZE  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MAN_WIDTH-1:0] mdata_in [IN_SIZE],
  input  logic [EXP_WIDTH-1:0] edata_in,
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic [MAN_WIDTH-1:0] mdata_out [OUT_SIZE],
  output logic [EXP_WIDTH-1:0] edata_out,
  output logic                 data_out_valid,
  input  logic                 data_out_ready,
  output logic                 data_out_last
);

  localparam int unsigned NUM_BEATS = IN_SIZE / OUT_SIZE;
  localparam int unsigned CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int unsigned IDX_W     = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);

  if ((OUT_SIZE == 0) || ((IN_SIZE % OUT_SIZE) != 0)) begin : g_bad_size
    $error("mx_block_serializer: IN_SIZE must be a nonzero multiple of OUT_SIZE");
  end

  logic                 busy;
  logic [CNT_W-1:0]     cnt;
  logic [MAN_WIDTH-1:0] hold_m [IN_SIZE];
  logic [EXP_WIDTH-1:0] hold_e;

  logic last_beat;
  logic in_hs;
  logic out_hs;

  assign last_beat     = busy && (cnt == LAST_CNT);
  assign out_hs        = busy && data_out_ready;
  // Ready looks through to data_out_ready so a new block can load on the
  // cycle the last beat leaves, giving one beat per cycle without a bubble.
  assign data_in_ready = !busy || (last_beat && data_out_ready);
  assign in_hs         = data_in_valid && data_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      hold_e <= '0;
      for (int unsigned i = 0; i < IN_SIZE; i++) begin
        hold_m[i] <= '0;
      end
    end else if (in_hs) begin
      busy   <= 1'b1;
      cnt    <= '0;
      hold_e <= edata_in;
      for (int unsigned i = 0; i < IN_SIZE; i++) begin
        hold_m[i] <= mdata_in[i];
      end
    end else if (out_hs) begin
      if (last_beat) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < OUT_SIZE; j++) begin
      mdata_out[j] = '0;
      if (busy) begin
        mdata_out[j] = hold_m[IDX_W'(32'(cnt) * OUT_SIZE + j)];
      end
    end
    edata_out      = busy ? hold_e : '0;
    data_out_valid = busy;
    data_out_last  = last_beat;
  end

endmodule

// File: tb/tb_mx_block_serializer.sv
// Bench for mx_block_serializer: directed literal checks plus a queue-based beat model
// for an 8->2 instance and a 4->4 instance, compared every negative clock edge.
module tb_mx_block_serializer;

  typedef struct packed {
    logic [31:0] m;
    logic [7:0]  e;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] a_m_in [8];
  logic [7:0] a_e_in;
  logic       a_vin, a_rdy_in;
  logic [7:0] a_m_out [2];
  logic [7:0] a_e_out;
  logic       a_vout, a_rout, a_last;

  logic [7:0] b_m_in [4];
  logic [7:0] b_e_in;
  logic       b_vin, b_rdy_in;
  logic [7:0] b_m_out [4];
  logic [7:0] b_e_out;
  logic       b_vout, b_rout, b_last;

  mx_block_serializer #(.MAN_WIDTH(8), .EXP_WIDTH(8), .IN_SIZE(8), .OUT_SIZE(2)) dut_a (
    .clk(clk), .rst(rst), .mdata_in(a_m_in), .edata_in(a_e_in),
    .data_in_valid(a_vin), .data_in_ready(a_rdy_in), .mdata_out(a_m_out),
    .edata_out(a_e_out), .data_out_valid(a_vout), .data_out_ready(a_rout),
    .data_out_last(a_last)
  );

  mx_block_serializer #(.MAN_WIDTH(8), .EXP_WIDTH(8), .IN_SIZE(4), .OUT_SIZE(4)) dut_b (
    .clk(clk), .rst(rst), .mdata_in(b_m_in), .edata_in(b_e_in),
    .data_in_valid(b_vin), .data_in_ready(b_rdy_in), .mdata_out(b_m_out),
    .edata_out(b_e_out), .data_out_valid(b_vout), .data_out_ready(b_rout),
    .data_out_last(b_last)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic beat_t a_cur();
    beat_t b;
    b.m = {16'h0, a_m_out[1], a_m_out[0]};
    b.e = a_e_out;
    b.last = a_last;
    return b;
  endfunction

  function automatic beat_t b_cur();
    beat_t b;
    b.m = {b_m_out[3], b_m_out[2], b_m_out[1], b_m_out[0]};
    b.e = b_e_out;
    b.last = b_last;
    return b;
  endfunction

  // Reference model: every accepted block becomes its list of expected beats.
  beat_t qa[$];
  beat_t qb[$];
  beat_t a_prev, b_prev;
  logic  a_stall = 1'b0;
  logic  b_stall = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      a_stall = 1'b0;
      chk("a_reset_outputs", 64'(a_cur()), 64'(0));
      chk("a_reset_valid", 64'(a_vout), 64'(0));
    end else begin
      chk("a_in_ready", 64'(a_rdy_in), 64'((qa.size() == 0) || (qa.size() == 1 && a_rout)));
      chk("a_out_valid", 64'(a_vout), 64'(qa.size() != 0));
      if (a_stall) chk("a_stall_stable", 64'(a_cur()), 64'(a_prev));
      if (a_vout && qa.size() != 0) chk("a_beat", 64'(a_cur()), 64'(qa[0]));
      a_stall = a_vout && !a_rout;
      a_prev  = a_cur();
      if (a_vout && a_rout && qa.size() != 0) void'(qa.pop_front());
      if (a_vin && a_rdy_in) begin
        for (int k = 0; k < 4; k++) begin
          beat_t nb;
          nb.m = {16'h0, a_m_in[2*k+1], a_m_in[2*k]};
          nb.e = a_e_in;
          nb.last = (k == 3);
          qa.push_back(nb);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      qb.delete();
      b_stall = 1'b0;
      chk("b_reset_outputs", 64'(b_cur()), 64'(0));
      chk("b_reset_valid", 64'(b_vout), 64'(0));
    end else begin
      chk("b_in_ready", 64'(b_rdy_in), 64'((qb.size() == 0) || (qb.size() == 1 && b_rout)));
      chk("b_out_valid", 64'(b_vout), 64'(qb.size() != 0));
      if (b_stall) chk("b_stall_stable", 64'(b_cur()), 64'(b_prev));
      if (b_vout && qb.size() != 0) chk("b_beat", 64'(b_cur()), 64'(qb[0]));
      b_stall = b_vout && !b_rout;
      b_prev  = b_cur();
      if (b_vout && b_rout && qb.size() != 0) void'(qb.pop_front());
      if (b_vin && b_rdy_in) begin
        beat_t nb;
        nb.m = {b_m_in[3], b_m_in[2], b_m_in[1], b_m_in[0]};
        nb.e = b_e_in;
        nb.last = 1'b1;
        qb.push_back(nb);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int accepted;
  int cycles;
  logic acc_now;
  logic [7:0] saved_m [4];
  logic [7:0] saved_e;

  initial begin
    for (int i = 0; i < 8; i++) a_m_in[i] = '0;
    for (int i = 0; i < 4; i++) b_m_in[i] = '0;
    a_e_in = '0; b_e_in = '0;
    a_vin = 1'b0; b_vin = 1'b0;
    a_rout = 1'b1; b_rout = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    step();

    // Basic replay: m[i]=i+1, e=0x7A, ready held high.
    chk("t1_in_ready_idle", 64'(a_rdy_in), 64'(1));
    for (int i = 0; i < 8; i++) a_m_in[i] = 8'(i + 1);
    a_e_in = 8'h7A; a_vin = 1'b1;
    step();
    a_vin = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t1_valid", 64'(a_vout), 64'(1));
      chk("t1_m0", 64'(a_m_out[0]), 64'(2*k + 1));
      chk("t1_m1", 64'(a_m_out[1]), 64'(2*k + 2));
      chk("t1_exp", 64'(a_e_out), 64'h7A);
      chk("t1_last", 64'(a_last), 64'(k == 3));
      step();
    end
    chk("t1_done_valid", 64'(a_vout), 64'(0));

    // Back-to-back blocks: B loads on A's last beat, no gap.
    for (int i = 0; i < 8; i++) a_m_in[i] = 8'(10 + i);
    a_e_in = 8'h11; a_vin = 1'b1;
    step();
    for (int i = 0; i < 8; i++) a_m_in[i] = 8'(20 + i);
    a_e_in = 8'h22;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t2_valid", 64'(a_vout), 64'(1));
      chk("t2_m0", 64'(a_m_out[0]), 64'((k < 4 ? 10 : 20) + 2*(k % 4)));
      chk("t2_exp", 64'(a_e_out), 64'(k < 4 ? 8'h11 : 8'h22));
      chk("t2_last", 64'(a_last), 64'(k % 4 == 3));
      if (k < 4) chk("t2_in_ready", 64'(a_rdy_in), 64'(k == 3));
      step();
      if (k == 3) a_vin = 1'b0;
    end
    chk("t2_done_valid", 64'(a_vout), 64'(0));

    // Stall on the last beat with a pending block: not taken, held data intact.
    for (int i = 0; i < 8; i++) a_m_in[i] = 8'(30 + i);
    a_e_in = 8'h33; a_vin = 1'b1;
    step();
    a_vin = 1'b0;
    repeat (3) step();
    a_rout = 1'b0;
    for (int i = 0; i < 8; i++) a_m_in[i] = 8'(40 + i);
    a_e_in = 8'h44; a_vin = 1'b1;
    #1;
    for (int r = 0; r < 3; r++) begin
      chk("t4_in_ready", 64'(a_rdy_in), 64'(0));
      chk("t4_m0", 64'(a_m_out[0]), 64'(36));
      chk("t4_m1", 64'(a_m_out[1]), 64'(37));
      chk("t4_exp", 64'(a_e_out), 64'h33);
      chk("t4_last", 64'(a_last), 64'(1));
      step();
    end
    a_rout = 1'b1;
    #1;
    chk("t4_in_ready_release", 64'(a_rdy_in), 64'(1));
    step();
    a_vin = 1'b0;
    chk("t4_next_m0", 64'(a_m_out[0]), 64'(40));
    chk("t4_next_exp", 64'(a_e_out), 64'h44);
    repeat (4) step();
    chk("t4_done_valid", 64'(a_vout), 64'(0));

    // Asynchronous reset in the middle of a block.
    for (int i = 0; i < 8; i++) a_m_in[i] = 8'(50 + i);
    a_e_in = 8'h55; a_vin = 1'b1;
    step();
    a_vin = 1'b0;
    step();
    chk("t5_beat1_m0", 64'(a_m_out[0]), 64'(52));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(a_vout), 64'(0));
    chk("t5_rst_m", 64'({a_m_out[1], a_m_out[0]}), 64'(0));
    chk("t5_rst_exp", 64'(a_e_out), 64'(0));
    chk("t5_rst_last", 64'(a_last), 64'(0));
    @(negedge clk);
    #2 rst = 1'b0;
    for (int r = 0; r < 5; r++) begin
      step();
      chk("t5_post_valid", 64'(a_vout), 64'(0));
      chk("t5_post_in_ready", 64'(a_rdy_in), 64'(1));
    end

    // Random traffic with random back-pressure; the model checks every cycle.
    accepted = 0;
    cycles = 0;
    while (accepted < 200 && cycles < 5000) begin
      if (!a_vin && $urandom_range(0, 3) != 0) begin
        for (int i = 0; i < 8; i++) a_m_in[i] = 8'($urandom);
        a_e_in = 8'($urandom);
        a_vin = 1'b1;
      end
      a_rout = 1'($urandom_range(0, 1));
      #1;
      acc_now = a_vin && a_rdy_in;
      if (acc_now) accepted++;
      step();
      if (acc_now) a_vin = 1'b0;
      cycles++;
    end
    chk("t3_blocks_accepted", 64'(accepted), 64'(200));
    a_vin = 1'b0;
    a_rout = 1'b1;
    cycles = 0;
    while (a_vout && cycles < 20) begin
      step();
      cycles++;
    end
    chk("t3_drained", 64'(a_vout), 64'(0));

    // Single-beat instance: one block per cycle, last always set.
    b_rout = 1'b1;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 4; i++) begin
        saved_m[i] = 8'($urandom);
        b_m_in[i] = saved_m[i];
      end
      saved_e = 8'($urandom);
      b_e_in = saved_e;
      b_vin = 1'b1;
      #1;
      chk("t6_in_ready", 64'(b_rdy_in), 64'(1));
      step();
      chk("t6_valid", 64'(b_vout), 64'(1));
      chk("t6_last", 64'(b_last), 64'(1));
      chk("t6_m", 64'({b_m_out[3], b_m_out[2], b_m_out[1], b_m_out[0]}),
          64'({saved_m[3], saved_m[2], saved_m[1], saved_m[0]}));
      chk("t6_exp", 64'(b_e_out), 64'(saved_e));
    end
    b_vin = 1'b0;
    step();
    chk("t6_done_valid", 64'(b_vout), 64'(0));

    for (int r = 0; r < 80; r++) begin
      if (!b_vin && $urandom_range(0, 2) != 0) begin
        for (int i = 0; i < 4; i++) b_m_in[i] = 8'($urandom);
        b_e_in = 8'($urandom);
        b_vin = 1'b1;
      end
      b_rout = 1'($urandom_range(0, 1));
      #1;
      acc_now = b_vin && b_rdy_in;
      step();
      if (acc_now) b_vin = 1'b0;
    end
    b_vin = 1'b0;
    b_rout = 1'b1;
    repeat (3) step();
    chk("t6_drained", 64'(b_vout), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
